pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl.sv | 81 ++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Groups every signal exchanged between the pipeline datapath and the
// hazard controller. clk and reset stay plain ports on the controller.
//   master : the pipeline side; drives D/E/M stage info, samples the controls
//   slave  : the hazard controller; samples stage info, drives the controls
// Stage info : rs_D, rt_D, tuse_rs_D, tuse_rt_D, wreg_E, wreg_M, tnew_E,
//              tnew_M, md_start_E, md_div_E, md_use_D
// Controls   : en_F, en_D, flush_E, md_busy, md_cnt, stall_cnt
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       rs_D;
    logic [4:0]       rt_D;
    logic [1:0]       tuse_rs_D;
    logic [1:0]       tuse_rt_D;
    logic [4:0]       wreg_E;
    logic [4:0]       wreg_M;
    logic [1:0]       tnew_E;
    logic [1:0]       tnew_M;
    logic             md_start_E;
    logic             md_div_E;
    logic             md_use_D;
    logic             en_F;
    logic             en_D;
    logic             flush_E;
    logic             md_busy;
    logic [3:0]       md_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, wreg_E, wreg_M,
               tnew_E, tnew_M, md_start_E, md_div_E, md_use_D,
        input  en_F, en_D, flush_E, md_busy, md_cnt, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, wreg_E, wreg_M,
               tnew_E, tnew_M, md_start_E, md_div_E, md_use_D,
        output en_F, en_D, flush_E, md_busy, md_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for a 5-stage pipeline. Compares the D-stage source
// registers against E/M destinations using Tuse/Tnew timing, and tracks the
// occupancy of the multi-cycle mult/div unit with a down-counter.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low; clears md_cnt and stall_cnt
//   hz    : pipe_hazard_ctrl_if.slave (stage info in, stall controls out)
// State is only the mult/div busy counter and the saturating stall counter;
// all control outputs are combinational from the inputs and md_cnt.
module pipe_hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam logic [3:0]       MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0]       DIV_LD  = 4'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_md_busy;
    logic w_hazard_rs;
    logic w_hazard_rt;
    logic w_hazard_md;
    logic w_stall;

    // busy is derived only from the registered count, so an op issuing in E
    // does not show up here until the following cycle
    assign w_md_busy = (r_md_cnt != 4'd0);

    // A hazard exists when the producer's result is not forwardable before
    // the consumer needs it (Tuse < Tnew). Register 0 is hard-wired, so it
    // never creates a dependency, even against a "no destination" of 0.
    assign w_hazard_rs = (hz.rs_D != 5'd0) &&
                         (((hz.rs_D == hz.wreg_E) && (hz.tuse_rs_D < hz.tnew_E)) ||
                          ((hz.rs_D == hz.wreg_M) && (hz.tuse_rs_D < hz.tnew_M)));

    assign w_hazard_rt = (hz.rt_D != 5'd0) &&
                         (((hz.rt_D == hz.wreg_E) && (hz.tuse_rt_D < hz.tnew_E)) ||
                          ((hz.rt_D == hz.wreg_M) && (hz.tuse_rt_D < hz.tnew_M)));

    // The issue cycle counts as occupied even though busy is still low.
    assign w_hazard_md = hz.md_use_D && (w_md_busy || hz.md_start_E);

    assign w_stall = w_hazard_rs || w_hazard_rt || w_hazard_md;

    assign hz.en_F      = !w_stall;
    assign hz.en_D      = !w_stall;
    assign hz.flush_E   = w_stall;
    assign hz.md_busy   = w_md_busy;
    assign hz.md_cnt    = r_md_cnt;
    assign hz.stall_cnt = r_stall_cnt;

    // A new issue always reloads, discarding any count still in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= 4'd0;
        end else if (hz.md_start_E) begin
            r_md_cnt <= hz.md_div_E ? DIV_LD : MULT_LD;
        end else if (r_md_cnt != 4'd0) begin
            r_md_cnt <= r_md_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

endmodule
